// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared definitions for the keypad/button event front end: event-kind
//   encodings, special key codes, the calculator state in which the minus
//   key acts as an operator, the event record stored in the queue and the
//   code-to-kind classifier.
//   No ports (package).
package key_event_pkg;

  localparam logic [2:0] KIND_DIGIT    = 3'd0;
  localparam logic [2:0] KIND_CLEAR    = 3'd1;
  localparam logic [2:0] KIND_EQUALS   = 3'd2;
  localparam logic [2:0] KIND_OPERATOR = 3'd3;
  localparam logic [2:0] KIND_NEGATIVE = 3'd4;
  localparam logic [2:0] KIND_BUTTON   = 3'd5;

  localparam logic [3:0] CODE_CLEAR  = 4'd10;
  localparam logic [3:0] CODE_EQUALS = 4'd11;
  localparam logic [3:0] CODE_MINUS  = 4'd14;

  localparam logic [3:0] STATE_OPERATOR_ENTRY = 4'd1;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] code;
  } event_t;

  // Minus is a binary operator only while the calculator expects one;
  // anywhere else it starts a negative number.
  function automatic logic [2:0] classify_code(input logic [3:0] code,
                                               input logic [3:0] state);
    if (code <= 4'd9)             return KIND_DIGIT;
    else if (code == CODE_CLEAR)  return KIND_CLEAR;
    else if (code == CODE_EQUALS) return KIND_EQUALS;
    else if (code == CODE_MINUS)
      return (state == STATE_OPERATOR_ENTRY) ? KIND_OPERATOR : KIND_NEGATIVE;
    else                          return KIND_OPERATOR;
  endfunction

endpackage

// File: rtl/key_code_lookup.sv
// key_code_lookup
//   Combinational keypad index -> key code table. Index is r*COLS+c; the
//   standard 4x4 calculator layout is used and any position outside it
//   maps to code 0.
//   Ports:
//     i_idx   in  IW  key index r*COLS+c
//     o_code  out 4   key code
module key_code_lookup #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IW   = 4
) (
  input  logic [IW-1:0] i_idx,
  output logic [3:0]    o_code
);

  always_comb begin
    int r;
    int c;
    o_code = 4'd0;
    r = int'(i_idx) / COLS;
    c = int'(i_idx) % COLS;
    if (r < 4 && c < 4 && r < ROWS) begin
      case (r * 4 + c)
        0:  o_code = 4'd1;
        1:  o_code = 4'd2;
        2:  o_code = 4'd3;
        3:  o_code = 4'd12;
        4:  o_code = 4'd4;
        5:  o_code = 4'd5;
        6:  o_code = 4'd6;
        7:  o_code = 4'd14;
        8:  o_code = 4'd7;
        9:  o_code = 4'd8;
        10: o_code = 4'd9;
        11: o_code = 4'd13;
        12: o_code = 4'd10;
        13: o_code = 4'd0;
        14: o_code = 4'd11;
        15: o_code = 4'd15;
        default: o_code = 4'd0;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns debounced keypad and button levels into typed calculator events
//   (press edges, auto-repeat, state-dependent minus) and buffers them in a
//   show-ahead FIFO with a valid/ready output handshake.
//   Ports:
//     Clock_10ms        in   tick clock
//     Reset             in   synchronous active-high reset
//     row/Column        in   one-hot keypad position
//     keypadValid       in   debounced key held
//     buttonPressed     in   held button index
//     validButtonPress  in   debounced button held
//     State             in   calculator FSM state
//     event_ready       in   consumer takes head event
//     event_valid/kind/code out  head event
//     operator          out  last operator latched in operator-entry state
//     overflow          out  sticky event-dropped flag
//     fill              out  FIFO occupancy
module key_event_queue #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int NUM_BUTTONS  = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int BW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic            Clock_10ms,
  input  logic            Reset,
  input  logic [ROWS-1:0] row,
  input  logic [COLS-1:0] Column,
  input  logic            keypadValid,
  input  logic [BW-1:0]   buttonPressed,
  input  logic            validButtonPress,
  input  logic [3:0]      State,
  input  logic            event_ready,
  output logic            event_valid,
  output logic [2:0]      event_kind,
  output logic [3:0]      event_code,
  output logic [3:0]      operator,
  output logic            overflow,
  output logic [AW:0]     fill
);
  import key_event_pkg::*;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int TW = $clog2(REPEAT_DELAY + 1);
  localparam logic [TW-1:0] T_FIRE = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_RELOAD = TW'(REPEAT_DELAY - REPEAT_RATE + 1);

  // Keypad decode
  logic [RW-1:0] w_r;
  logic [CW-1:0] w_c;
  logic [IW-1:0] w_idx;
  logic          w_kp_ok;
  logic [3:0]    w_kp_code;
  logic [2:0]    w_kp_kind;

  always_comb begin
    w_r = '0;
    w_c = '0;
    for (int i = 0; i < ROWS; i++) if (row[i]) w_r = RW'(i);
    for (int j = 0; j < COLS; j++) if (Column[j]) w_c = CW'(j);
  end

  assign w_kp_ok = keypadValid
                && (row != '0) && ((row & (row - 1'b1)) == '0)
                && (Column != '0) && ((Column & (Column - 1'b1)) == '0);
  assign w_idx = IW'(int'(w_r) * COLS + int'(w_c));

  key_code_lookup #(.ROWS(ROWS), .COLS(COLS), .IW(IW)) u_lookup (
    .i_idx  (w_idx),
    .o_code (w_kp_code)
  );

  assign w_kp_kind = classify_code(w_kp_code, State);

  // Edge / repeat tracking. r_*_block suppresses a level that was already
  // held across Reset until it is released.
  logic          r_kp_held, r_kp_block;
  logic [IW-1:0] r_kp_idx;
  logic [TW-1:0] r_kp_cnt;
  logic          r_bt_held, r_bt_block;
  logic [BW-1:0] r_bt_idx;
  logic [TW-1:0] r_bt_cnt;

  logic w_kp_live, w_kp_same, w_kp_press, w_kp_rep, w_kp_ev;
  logic w_bt_live, w_bt_same, w_bt_press, w_bt_rep, w_bt_ev;

  assign w_kp_live  = w_kp_ok && !r_kp_block;
  assign w_kp_same  = r_kp_held && (w_idx == r_kp_idx);
  assign w_kp_press = w_kp_live && !w_kp_same;
  assign w_kp_rep   = w_kp_live && w_kp_same && (w_kp_kind == KIND_DIGIT)
                   && (r_kp_cnt == T_FIRE);
  assign w_kp_ev    = w_kp_press || w_kp_rep;

  assign w_bt_live  = validButtonPress && !r_bt_block;
  assign w_bt_same  = r_bt_held && (buttonPressed == r_bt_idx);
  assign w_bt_press = w_bt_live && !r_bt_held;
  assign w_bt_rep   = w_bt_live && w_bt_same && (buttonPressed == '0)
                   && (r_bt_cnt == T_FIRE);
  assign w_bt_ev    = w_bt_press || w_bt_rep;

  always_ff @(posedge Clock_10ms) begin
    if (Reset) begin
      r_kp_held  <= 1'b0;
      r_kp_block <= w_kp_ok;
      r_kp_idx   <= '0;
      r_kp_cnt   <= '0;
      r_bt_held  <= 1'b0;
      r_bt_block <= validButtonPress;
      r_bt_idx   <= '0;
      r_bt_cnt   <= '0;
    end else begin
      r_kp_held  <= w_kp_live;
      r_kp_block <= r_kp_block && w_kp_ok;
      if (w_kp_live) r_kp_idx <= w_idx;
      if (w_kp_press)    r_kp_cnt <= TW'(1);
      else if (w_kp_rep) r_kp_cnt <= T_RELOAD;
      else if (w_kp_live && r_kp_cnt != T_FIRE) r_kp_cnt <= r_kp_cnt + 1'b1;
      else if (!w_kp_live) r_kp_cnt <= '0;

      r_bt_held  <= w_bt_live;
      r_bt_block <= r_bt_block && validButtonPress;
      if (w_bt_live) r_bt_idx <= buttonPressed;
      if (w_bt_press)    r_bt_cnt <= TW'(1);
      else if (w_bt_rep) r_bt_cnt <= T_RELOAD;
      else if (w_bt_live && !w_bt_same) r_bt_cnt <= '0;
      else if (w_bt_live && r_bt_cnt != T_FIRE) r_bt_cnt <= r_bt_cnt + 1'b1;
      else if (!w_bt_live) r_bt_cnt <= '0;
    end
  end

  // Write arbitration: one FIFO write per tick. Oldest first: pending slot,
  // then keypad, then button; the runner-up waits in the pending slot and
  // a third simultaneous event is lost.
  event_t w_kp_evt, w_bt_evt, w_wr_evt, w_pend_evt, r_pend;
  logic   w_wr_req, w_pend_load, w_lost, r_pend_vld;

  assign w_kp_evt = '{kind: w_kp_kind, code: w_kp_code};
  assign w_bt_evt = '{kind: KIND_BUTTON, code: 4'(buttonPressed)};

  always_comb begin
    w_wr_req    = 1'b0;
    w_wr_evt    = '0;
    w_pend_load = 1'b0;
    w_pend_evt  = '0;
    w_lost      = 1'b0;
    if (r_pend_vld) begin
      w_wr_req = 1'b1;
      w_wr_evt = r_pend;
      if (w_kp_ev) begin
        w_pend_load = 1'b1;
        w_pend_evt  = w_kp_evt;
        w_lost      = w_bt_ev;
      end else if (w_bt_ev) begin
        w_pend_load = 1'b1;
        w_pend_evt  = w_bt_evt;
      end
    end else if (w_kp_ev) begin
      w_wr_req = 1'b1;
      w_wr_evt = w_kp_evt;
      if (w_bt_ev) begin
        w_pend_load = 1'b1;
        w_pend_evt  = w_bt_evt;
      end
    end else if (w_bt_ev) begin
      w_wr_req = 1'b1;
      w_wr_evt = w_bt_evt;
    end
  end

  // Show-ahead FIFO, pointers carry a wrap bit
  event_t        r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr, r_rd;
  logic [3:0]    r_op;
  logic          r_ovf;
  logic          w_pop, w_full, w_push, w_drop;
  event_t        w_head;

  assign fill        = r_wr - r_rd;
  assign event_valid = (r_wr != r_rd);
  assign w_head      = r_mem[r_rd[AW-1:0]];
  assign event_kind  = event_valid ? w_head.kind : 3'd0;
  assign event_code  = event_valid ? w_head.code : 4'd0;
  assign operator    = r_op;
  assign overflow    = r_ovf;

  assign w_pop  = event_valid && event_ready;
  assign w_full = (fill == (AW+1)'(FIFO_DEPTH));
  assign w_push = w_wr_req && (!w_full || w_pop);
  assign w_drop = (w_wr_req && !w_push) || w_lost;

  always_ff @(posedge Clock_10ms) begin
    if (Reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_pend_vld <= 1'b0;
      r_op       <= 4'd0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_pend_vld <= w_pend_load;
      if (w_push && w_wr_evt.kind == KIND_OPERATOR && State == STATE_OPERATOR_ENTRY)
        r_op <= w_wr_evt.code;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clock_10ms) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_wr_evt;
    if (w_pend_load) r_pend <= w_pend_evt;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
//   Scoreboard bench for key_event_queue: stimulus pushes expected events
//   (kind, code, optional arrival cycle); a negedge monitor pops and compares
//   every accepted head event.
module tb_key_event_queue;
  import key_event_pkg::*;

  localparam int ROWS = 4, COLS = 4, NB = 4, DEPTH = 4, RD = 50, RR = 10;

  logic            clk = 1'b0;
  logic            Reset;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] Column;
  logic            keypadValid;
  logic [1:0]      buttonPressed;
  logic            validButtonPress;
  logic [3:0]      State;
  logic            event_ready;
  logic            event_valid;
  logic [2:0]      event_kind;
  logic [3:0]      event_code;
  logic [3:0]      operator;
  logic            overflow;
  logic [2:0]      fill;

  always #5 clk = ~clk;

  key_event_queue #(
    .ROWS(ROWS), .COLS(COLS), .NUM_BUTTONS(NB), .FIFO_DEPTH(DEPTH),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clock_10ms(clk), .Reset(Reset), .row(row), .Column(Column),
    .keypadValid(keypadValid), .buttonPressed(buttonPressed),
    .validButtonPress(validButtonPress), .State(State),
    .event_ready(event_ready), .event_valid(event_valid),
    .event_kind(event_kind), .event_code(event_code),
    .operator(operator), .overflow(overflow), .fill(fill)
  );

  typedef struct { int kind; int code; int cyc; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!Reset && event_valid && event_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_event", int'(event_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", int'(event_kind), e.kind);
        chk("ev_code", int'(event_code), e.code);
        if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] r, input logic [3:0] c);
    row = r;
    Column = c;
    keypadValid = 1'b1;
  endtask

  task automatic release_all();
    keypadValid = 1'b0;
    row = '0;
    Column = '0;
    validButtonPress = 1'b0;
  endtask

  task automatic expect_ev(int k, int code, int at);
    exp_t e;
    e = '{k, code, at};
    sb.push_back(e);
  endtask

  task automatic drain(string tag);
    tick(6);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  logic [3:0] ovf_rows [5];
  logic [3:0] ovf_cols [5];
  int t;

  initial begin
    ovf_rows = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    ovf_cols = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    Reset = 1'b1;
    release_all();
    buttonPressed = '0;
    State = 4'd0;
    event_ready = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_kind", int'(event_kind), 0);
    chk("rst_code", int'(event_code), 0);
    chk("rst_operator", int'(operator), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_fill", int'(fill), 0);

    // single digit press held 3 ticks
    key(4'b0001, 4'b0010);
    expect_ev(KIND_DIGIT, 2, cyc + 1);
    tick(3);
    release_all();
    drain("digit2_count");

    // minus as operator / negative, operator register behaviour
    State = 4'd1;
    key(4'b0010, 4'b1000);
    expect_ev(KIND_OPERATOR, 14, cyc + 1);
    tick(2); release_all(); tick(2);
    chk("op_latch_minus", int'(operator), 14);
    State = 4'd3;
    key(4'b0010, 4'b1000);
    expect_ev(KIND_NEGATIVE, 14, cyc + 1);
    tick(2); release_all(); tick(2);
    chk("op_hold_negative", int'(operator), 14);
    key(4'b0001, 4'b1000);
    expect_ev(KIND_OPERATOR, 12, cyc + 1);
    tick(2); release_all(); tick(2);
    chk("op_hold_state3", int'(operator), 14);
    State = 4'd1;
    key(4'b0100, 4'b1000);
    expect_ev(KIND_OPERATOR, 13, cyc + 1);
    tick(2); release_all(); tick(2);
    chk("op_latch_times", int'(operator), 13);
    State = 4'd0;
    drain("operator_count");

    // auto-repeat on digit 5, none on clear
    key(4'b0010, 4'b0010);
    t = cyc;
    expect_ev(KIND_DIGIT, 5, t + 1);
    expect_ev(KIND_DIGIT, 5, t + 1 + RD);
    expect_ev(KIND_DIGIT, 5, t + 1 + RD + RR);
    expect_ev(KIND_DIGIT, 5, t + 1 + RD + 2 * RR);
    tick(75);
    release_all();
    drain("repeat_digit_count");
    key(4'b1000, 4'b0001);
    expect_ev(KIND_CLEAR, 10, cyc + 1);
    tick(75);
    release_all();
    drain("clear_no_repeat");

    // backspace button auto-repeat
    buttonPressed = 2'd0;
    validButtonPress = 1'b1;
    t = cyc;
    expect_ev(KIND_BUTTON, 0, t + 1);
    expect_ev(KIND_BUTTON, 0, t + 1 + RD);
    expect_ev(KIND_BUTTON, 0, t + 1 + RD + RR);
    tick(62);
    release_all();
    drain("repeat_button_count");

    // simultaneous keypad equals and button 2
    key(4'b1000, 4'b0100);
    buttonPressed = 2'd2;
    validButtonPress = 1'b1;
    expect_ev(KIND_EQUALS, 11, cyc + 1);
    expect_ev(KIND_BUTTON, 2, cyc + 2);
    tick(2);
    release_all();
    drain("simultaneous_count");

    // overflow with consumer stalled
    event_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key(ovf_rows[i], ovf_cols[i]);
      if (i < 4) expect_ev(KIND_DIGIT, i + 1, -1);
      tick(1);
      release_all();
      tick(1);
    end
    chk("full_fill", int'(fill), 4);
    chk("full_overflow", int'(overflow), 1);
    chk("full_head_code", int'(event_code), 1);
    event_ready = 1'b1;
    drain("overflow_order");
    chk("overflow_sticky", int'(overflow), 1);
    chk("drained_fill", int'(fill), 0);
    event_ready = 1'b0;
    key(4'b0001, 4'b0001);
    tick(1); release_all(); tick(1);
    chk("pre_reset_fill", int'(fill), 1);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(1);
    chk("post_reset_fill", int'(fill), 0);
    chk("post_reset_overflow", int'(overflow), 0);
    event_ready = 1'b1;

    // non one-hot row bus
    key(4'b0011, 4'b0010);
    tick(4);
    release_all();
    drain("bad_row_no_event");
    chk("bad_row_fill", int'(fill), 0);

    // reset while a key is held
    key(4'b0100, 4'b0001);
    expect_ev(KIND_DIGIT, 7, cyc + 1);
    tick(3);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(5);
    release_all();
    tick(4);
    chk("held_reset_fill", int'(fill), 0);
    drain("held_reset_no_event");
    key(4'b0100, 4'b0001);
    expect_ev(KIND_DIGIT, 7, cyc + 1);
    tick(2);
    release_all();
    drain("repress_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
